// File: rtl/rtc_pkg.sv
// Shared field layout, BCD helpers and calendar rules for the RTC time keeper.
package rtc_pkg;

  localparam int SEC_LSB  = 0;
  localparam int MIN_LSB  = 8;
  localparam int HOUR_LSB = 16;
  localparam int DATE_LSB = 24;
  localparam int MON_LSB  = 32;
  localparam int YEAR_LSB = 40;
  localparam int WDAY_LSB = 48;
  localparam int PAD_LSB  = 56;
  localparam int TOG_BIT  = 64;

  typedef struct packed {
    logic       tog;
    logic [7:0] pad;
    logic [7:0] wday;
    logic [7:0] year;
    logic [7:0] month;
    logic [7:0] date;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] sec;
  } rtc_time_t;

  localparam rtc_time_t RTC_RESET = '{tog: 1'b0, pad: 8'h00, wday: 8'h00, year: 8'h00,
                                      month: 8'h01, date: 8'h01, hour: 8'h00,
                                      minute: 8'h00, sec: 8'h00};

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Digits above 9 are clamped to 9 so malformed HPS data still carries sanely.
  function automatic logic [7:0] bcd_sat(input logic [7:0] value);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = (value[7:4] > 4'd9) ? 4'd9 : value[7:4];
    units = (value[3:0] > 4'd9) ? 4'd9 : value[3:0];
    return {tens, units};
  endfunction

  function automatic logic bcd_at_max(input logic [7:0] value, input logic [7:0] max_v);
    return bcd_sat(value) >= max_v;
  endfunction

  function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] value, input logic [7:0] max_v,
                                              input logic [7:0] min_v);
    logic [7:0] v;
    v = bcd_sat(value);
    if (v >= max_v) return min_v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  function automatic logic is_leap(input logic [7:0] year);
    logic [7:0] y;
    y = bcd_sat(year);
    if (y[4]) return (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
    return (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic [7:0] year);
    case (bcd_sat(month))
      8'h02:                      return is_leap(year) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

endpackage

// File: rtl/rtc_time_keeper_prescaler.sv
// Divides clk down to the 10 Hz enable and the once-per-second calendar tick.
module rtc_prescaler
  import rtc_pkg::*;
#(
  parameter int CLK_HZ         = 21477270,
  parameter int TENTHS_PER_SEC = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic ce_10hz,
  output logic sec_tick
);

  localparam int PRESC_N = CLK_HZ / 10;
  localparam int PW      = cnt_w(PRESC_N);
  localparam int TW      = cnt_w(TENTHS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(PRESC_N - 1);
  localparam logic [TW-1:0] TENTHS_LAST = TW'(TENTHS_PER_SEC - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tenths_q, tenths_d;
  logic          ce_q, ce_d;
  logic          term;

  assign term     = (presc_q == PRESC_LAST);
  // A clear (HPS reload) drops any tick that would land on the same edge.
  assign sec_tick = term && (tenths_q == TENTHS_LAST) && !clear;
  assign ce_10hz  = ce_q;

  always_comb begin
    presc_d  = presc_q + 1'b1;
    tenths_d = tenths_q;
    ce_d     = 1'b0;
    if (clear) begin
      presc_d  = '0;
      tenths_d = '0;
    end else if (term) begin
      presc_d  = '0;
      ce_d     = 1'b1;
      tenths_d = (tenths_q == TENTHS_LAST) ? '0 : tenths_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      tenths_q <= '0;
      ce_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      tenths_q <= tenths_d;
      ce_q     <= ce_d;
    end
  end

endmodule

// File: rtl/rtc_time_keeper.sv
// Keeps a free-running BCD calendar between HPS wall-clock updates for the MSX RTC.
module rtc_time_keeper
  import rtc_pkg::*;
#(
  parameter int CLK_HZ         = 21477270,
  parameter int TENTHS_PER_SEC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [64:0] hps_rtc,
  output logic        ce_10hz,
  output logic [64:0] rt_out,
  output logic        valid
);

  rtc_time_t time_q, time_d;
  rtc_time_t hps_t;
  logic      tog_ref_q, tog_ref_d;
  logic      valid_q, valid_d;
  logic      reload, load, sec_tick;
  logic      sec_c, min_c, hour_c, date_c, mon_c;

  assign reload = valid_q && (hps_rtc[TOG_BIT] != tog_ref_q);
  assign load   = !valid_q || reload;
  assign rt_out = time_q;
  assign valid  = valid_q;

  rtc_prescaler #(
    .CLK_HZ        (CLK_HZ),
    .TENTHS_PER_SEC(TENTHS_PER_SEC)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .clear   (reload),
    .ce_10hz (ce_10hz),
    .sec_tick(sec_tick)
  );

  always_comb begin
    hps_t        = RTC_RESET;
    hps_t.sec    = hps_rtc[SEC_LSB  +: 8];
    hps_t.minute = hps_rtc[MIN_LSB  +: 8];
    hps_t.hour   = hps_rtc[HOUR_LSB +: 8];
    hps_t.date   = hps_rtc[DATE_LSB +: 8];
    hps_t.month  = hps_rtc[MON_LSB  +: 8];
    hps_t.year   = hps_rtc[YEAR_LSB +: 8];
    hps_t.wday   = hps_rtc[WDAY_LSB +: 8];
    hps_t.pad    = hps_rtc[PAD_LSB  +: 8];
    hps_t.tog    = hps_rtc[TOG_BIT];
  end

  always_comb begin
    sec_c  = bcd_at_max(time_q.sec, 8'h59);
    min_c  = sec_c  && bcd_at_max(time_q.minute, 8'h59);
    hour_c = min_c  && bcd_at_max(time_q.hour, 8'h23);
    date_c = hour_c && bcd_at_max(time_q.date, days_in_month(time_q.month, time_q.year));
    mon_c  = date_c && bcd_at_max(time_q.month, 8'h12);
  end

  // A load always wins over a second advance on the same edge.
  always_comb begin
    time_d    = time_q;
    tog_ref_d = tog_ref_q;
    valid_d   = valid_q;
    if (load) begin
      time_d     = hps_t;
      time_d.tog = ~time_q.tog;
      tog_ref_d  = hps_t.tog;
      valid_d    = 1'b1;
    end else if (sec_tick) begin
      time_d.sec = bcd_inc_wrap(time_q.sec, 8'h59, 8'h00);
      if (sec_c) time_d.minute = bcd_inc_wrap(time_q.minute, 8'h59, 8'h00);
      if (min_c) time_d.hour   = bcd_inc_wrap(time_q.hour, 8'h23, 8'h00);
      if (hour_c) begin
        time_d.date = bcd_inc_wrap(time_q.date, days_in_month(time_q.month, time_q.year), 8'h01);
        time_d.wday = bcd_inc_wrap(time_q.wday, 8'h06, 8'h00);
      end
      if (date_c) time_d.month = bcd_inc_wrap(time_q.month, 8'h12, 8'h01);
      if (mon_c)  time_d.year  = bcd_inc_wrap(time_q.year, 8'h99, 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_q    <= RTC_RESET;
      tog_ref_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      time_q    <= time_d;
      tog_ref_q <= tog_ref_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_rtc_time_keeper.sv
// Scenario bench for rtc_time_keeper with an integer-arithmetic calendar reference model.
module tb_rtc_time_keeper;

  localparam int CLK_HZ  = 100;
  localparam int PRESC_N = CLK_HZ / 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [64:0] hps_rtc = '0;
  logic        ce_10hz;
  logic        valid;
  logic [64:0] rt_out;

  int n_checks = 0;
  int n_pass   = 0;

  int          m_presc = 0;
  int          m_tenths = 0;
  logic        m_ce = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_togref = 1'b0;
  logic [64:0] m_rt = '0;

  rtc_time_keeper #(.CLK_HZ(CLK_HZ), .TENTHS_PER_SEC(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .hps_rtc(hps_rtc),
    .ce_10hz(ce_10hz),
    .rt_out (rt_out),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [64:0] mk(input logic tog, input logic [7:0] wd, input logic [7:0] yr,
                                     input logic [7:0] mo, input logic [7:0] dt, input logic [7:0] hr,
                                     input logic [7:0] mn, input logic [7:0] sc);
    return {tog, 8'h00, wd, yr, mo, dt, hr, mn, sc};
  endfunction

  function automatic int dec(input logic [7:0] b);
    int t, u;
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    if (t > 9) t = 9;
    if (u > 9) u = 9;
    return t * 10 + u;
  endfunction

  function automatic logic [7:0] enc(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int dim(input int mo, input int yr);
    if (mo == 2) return (yr % 4 == 0) ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    return 31;
  endfunction

  function automatic logic [64:0] advance(input logic [64:0] v);
    logic [64:0] r;
    int s, m, h, d, mo, yr, wd;
    r = v;
    s = dec(v[7:0]);
    if (s < 59) begin r[7:0] = enc(s + 1); return r; end
    r[7:0] = 8'h00;
    m = dec(v[15:8]);
    if (m < 59) begin r[15:8] = enc(m + 1); return r; end
    r[15:8] = 8'h00;
    h = dec(v[23:16]);
    if (h < 23) begin r[23:16] = enc(h + 1); return r; end
    r[23:16] = 8'h00;
    wd = dec(v[55:48]);
    r[55:48] = (wd >= 6) ? 8'h00 : enc(wd + 1);
    d  = dec(v[31:24]);
    mo = dec(v[39:32]);
    yr = dec(v[47:40]);
    if (d < dim(mo, yr)) begin r[31:24] = enc(d + 1); return r; end
    r[31:24] = 8'h01;
    if (mo < 12) begin r[39:32] = enc(mo + 1); return r; end
    r[39:32] = 8'h01;
    r[47:40] = (yr < 99) ? enc(yr + 1) : 8'h00;
    return r;
  endfunction

  function automatic logic [7:0] rnd_field(input int lo, input int hi);
    int sel;
    sel = $urandom_range(0, 15);
    if (sel == 0) return 8'($urandom);
    if (sel < 9) return enc(hi - int'($urandom_range(0, 2)));
    return enc(int'($urandom_range(lo, hi)));
  endfunction

  always @(posedge clk) begin : model
    bit ld, rl, tk;
    tk = 1'b0;
    if (reset) begin
      m_presc  <= 0;
      m_tenths <= 0;
      m_ce     <= 1'b0;
      m_valid  <= 1'b0;
      m_togref <= 1'b0;
      m_rt     <= mk(1'b0, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
    end else begin
      rl = m_valid && (hps_rtc[64] != m_togref);
      ld = !m_valid || rl;
      if (rl) begin
        m_presc <= 0; m_tenths <= 0; m_ce <= 1'b0;
      end else if (m_presc == PRESC_N - 1) begin
        m_presc  <= 0;
        m_ce     <= 1'b1;
        tk       = (m_tenths == 9);
        m_tenths <= (m_tenths + 1) % 10;
      end else begin
        m_presc <= m_presc + 1;
        m_ce    <= 1'b0;
      end
      if (ld) begin
        m_rt     <= {~m_rt[64], hps_rtc[63:0]};
        m_togref <= hps_rtc[64];
        m_valid  <= 1'b1;
      end else if (tk) begin
        m_rt <= advance(m_rt);
      end
    end
  end

  task automatic pulse_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic wait_pulses(input int n, output bit ok);
    int seen;
    seen = 0;
    ok   = 1'b0;
    for (int i = 0; i < n * 20 + 50; i++) begin
      @(negedge clk);
      if (ce_10hz) seen++;
      if (seen == n) begin ok = 1'b1; return; end
    end
  endtask

  task automatic measure_gap(output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!ce_10hz && gap < 40);
  endtask

  task automatic test_reset();
    logic [64:0] rst_v, v;
    rst_v = mk(1'b0, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
    v     = mk(1'b1, 8'h03, 8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    hps_rtc = v;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    n_checks++; if (rt_out !== rst_v) $display("FAIL reset_rt: got %h want %h", rt_out, rst_v); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
    n_checks++; if (ce_10hz !== 1'b0) $display("FAIL reset_ce: got %b want 0", ce_10hz); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (rt_out !== v) $display("FAIL first_load_rt: got %h want %h", rt_out, v); else n_pass++;
    n_checks++; if (valid !== 1'b1) $display("FAIL first_load_valid: got %b want 1", valid); else n_pass++;
  endtask

  task automatic test_calendar();
    logic [64:0] cin[7];
    logic [64:0] cout[7];
    logic [64:0] ld_v;
    bit ok;
    cin[0] = mk(1'b1, 8'h03, 8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    cout[0] = mk(1'b1, 8'h04, 8'h24, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00);
    cin[1] = mk(1'b1, 8'h03, 8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    cout[1] = mk(1'b1, 8'h04, 8'h23, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00);
    cin[2] = mk(1'b1, 8'h06, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
    cout[2] = mk(1'b1, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
    cin[3] = mk(1'b1, 8'h02, 8'h24, 8'h05, 8'h10, 8'h12, 8'h34, 8'h60);
    cout[3] = mk(1'b1, 8'h02, 8'h24, 8'h05, 8'h10, 8'h12, 8'h35, 8'h00);
    cin[4] = mk(1'b0, 8'h01, 8'h24, 8'h04, 8'h32, 8'h23, 8'h59, 8'h59);
    cout[4] = mk(1'b1, 8'h02, 8'h24, 8'h05, 8'h01, 8'h00, 8'h00, 8'h00);
    cin[5] = mk(1'b1, 8'h05, 8'h21, 8'h06, 8'h30, 8'h23, 8'h5A, 8'h5B);
    cout[5] = mk(1'b1, 8'h06, 8'h21, 8'h07, 8'h01, 8'h00, 8'h00, 8'h00);
    cin[6] = mk(1'b1, 8'h01, 8'h00, 8'h02, 8'h29, 8'h23, 8'h59, 8'h59);
    cout[6] = mk(1'b1, 8'h02, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 7; k++) begin
      hps_rtc = cin[k];
      pulse_reset();
      @(negedge clk);
      ld_v = {1'b1, cin[k][63:0]};
      n_checks++; if (rt_out !== ld_v) $display("FAIL cal_load[%0d]: got %h want %h", k, rt_out, ld_v); else n_pass++;
      n_checks++; if (valid !== 1'b1) $display("FAIL cal_valid[%0d]: got %b want 1", k, valid); else n_pass++;
      wait_pulses(9, ok);
      n_checks++; if (!ok) $display("FAIL cal_wait9[%0d]: got timeout want 9 pulses", k); else n_pass++;
      n_checks++; if (rt_out !== ld_v) $display("FAIL cal_hold[%0d]: got %h want %h", k, rt_out, ld_v); else n_pass++;
      wait_pulses(1, ok);
      n_checks++; if (!ok) $display("FAIL cal_wait10[%0d]: got timeout want pulse", k); else n_pass++;
      n_checks++; if (rt_out !== cout[k]) $display("FAIL cal_adv[%0d]: got %h want %h", k, rt_out, cout[k]); else n_pass++;
    end
  endtask

  task automatic test_cadence_reload();
    logic [64:0] v, nv, exp_v;
    bit ok;
    int gap;
    v  = mk(1'b0, 8'h02, 8'h25, 8'h07, 8'h14, 8'h10, 8'h20, 8'h30);
    nv = mk(1'b1, 8'h03, 8'h25, 8'h07, 8'h15, 8'h11, 8'h00, 8'h00);
    hps_rtc = v;
    pulse_reset();
    wait_pulses(1, ok);
    n_checks++; if (!ok) $display("FAIL cad_first: got timeout want pulse"); else n_pass++;
    for (int g = 0; g < 3; g++) begin
      measure_gap(gap);
      n_checks++; if (gap != 10) $display("FAIL cad_gap[%0d]: got %0d want 10", g, gap); else n_pass++;
    end
    repeat (9) @(negedge clk);
    hps_rtc = nv;
    @(negedge clk);
    exp_v = {1'b0, nv[63:0]};
    n_checks++; if (ce_10hz !== 1'b0) $display("FAIL reload_ce_drop: got %b want 0", ce_10hz); else n_pass++;
    n_checks++; if (rt_out !== exp_v) $display("FAIL reload_rt: got %h want %h", rt_out, exp_v); else n_pass++;
    measure_gap(gap);
    n_checks++; if (gap != 10) $display("FAIL reload_gap: got %0d want 10", gap); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [64:0] v, v2, rst_v, exp_v;
    bit ok;
    rst_v = mk(1'b0, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);
    v  = mk(1'b0, 8'h05, 8'h30, 8'h11, 8'h30, 8'h08, 8'h15, 8'h45);
    v2 = mk(1'b0, 8'h04, 8'h31, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
    hps_rtc = v;
    pulse_reset();
    wait_pulses(2, ok);
    n_checks++; if (!ok) $display("FAIL mid_wait: got timeout want 2 pulses"); else n_pass++;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (ce_10hz !== 1'b0) $display("FAIL mid_reset_ce: got %b want 0", ce_10hz); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", valid); else n_pass++;
    n_checks++; if (rt_out !== rst_v) $display("FAIL mid_reset_rt: got %h want %h", rt_out, rst_v); else n_pass++;
    reset = 1'b0;
    hps_rtc = v2;
    @(negedge clk);
    exp_v = {1'b1, v2[63:0]};
    n_checks++; if (rt_out !== exp_v) $display("FAIL mid_reload_rt: got %h want %h", rt_out, exp_v); else n_pass++;
    n_checks++; if (valid !== 1'b1) $display("FAIL mid_reload_valid: got %b want 1", valid); else n_pass++;
  endtask

  task automatic test_random();
    hps_rtc = mk(1'b0, 8'h06, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h50);
    pulse_reset();
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      n_checks++; if (rt_out !== m_rt) $display("FAIL rnd_rt@%0d: got %h want %h", i, rt_out, m_rt); else n_pass++;
      n_checks++; if (valid !== m_valid) $display("FAIL rnd_valid@%0d: got %b want %b", i, valid, m_valid); else n_pass++;
      n_checks++; if (ce_10hz !== m_ce) $display("FAIL rnd_ce@%0d: got %b want %b", i, ce_10hz, m_ce); else n_pass++;
      reset = ($urandom_range(0, 999) == 0);
      case ($urandom_range(0, 299))
        0: hps_rtc = mk(~hps_rtc[64], rnd_field(0, 6), rnd_field(0, 99), rnd_field(1, 12),
                        rnd_field(1, 31), rnd_field(0, 23), rnd_field(0, 59), rnd_field(0, 59));
        1: hps_rtc = mk(hps_rtc[64], rnd_field(0, 6), rnd_field(0, 99), rnd_field(1, 12),
                        rnd_field(1, 31), rnd_field(0, 23), rnd_field(0, 59), rnd_field(0, 59));
        default: ;
      endcase
    end
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_calendar();
    test_cadence_reload();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rtc_time_keeper.md
Name: rtc_time_keeper

Overview:
- Upstream feeder for the MSX RTC device.
- Accepts the HPS wall-clock vector (65 bits, BCD fields, bit 64 toggles on every update) and keeps a free-running BCD calendar between HPS updates.
- Produces the one-cycle 10 Hz clock enable for clock_bus.ce_10hz and a re-timed 65-bit time vector for the RTC's rt input.
- Sits between hps_io and the RTC device wrapper, on the cpu_bus clock.

Parameters:
- CLK_HZ, 21477270, frequency of clk in Hz; sets the prescaler terminal count.
- TENTHS_PER_SEC, 10, number of ce_10hz pulses per second of advance.

Ports:
- clk  in  1  system clock, the same clock as cpu_bus.clk
- reset  in  1  synchronous, active-high reset
- hps_rtc  in  65  HPS time: [7:0] sec, [15:8] min, [23:16] hour, [31:24] date, [39:32] month, [47:40] year 00-99, [55:48] weekday 0-6, [64] update toggle; fields in BCD
- ce_10hz  out  1  one-cycle pulse at 10 Hz
- rt_out  out  65  current time, same layout as hps_rtc; bit 64 toggles on every HPS reload
- valid  out  1  high once a time has been loaded since reset

Behaviour:
- Reset is synchronous and active-high. In the reset cycle:
  - prescaler = 0, tenths = 0
  - ce_10hz = 0, valid = 0
  - rt_out fields = 00:00:00, date 01, month 01, year 00, weekday 0, bit 64 = 0
  - tog_ref = 0
- First load after reset: on the first cycle with reset low and valid = 0, load every hps_rtc field into rt_out and set tog_ref = hps_rtc[64]. rt_out[64] toggles and valid becomes 1 on the next edge. This load happens regardless of the toggle state.
- Reload: when valid = 1 and hps_rtc[64] != tog_ref:
  - load all fields, set tog_ref = hps_rtc[64], invert rt_out[64]
  - clear prescaler and tenths
  - suppress ce_10hz for that cycle
- Reload latency: rt_out reflects the new value 1 cycle after the toggle edge is presented.
- Prescaler: counts 0..CLK_HZ/10-1. At the terminal count it wraps to 0 and ce_10hz = 1 for exactly one cycle (registered output), then tenths increments.
- Tenths: counts 0..TENTHS_PER_SEC-1. On wrap, the calendar advances one second in the same edge as the ce_10hz pulse.
- Calendar increment, all fields BCD:
  - sec 00-59 carries to min 00-59, which carries to hour 00-23, which carries to date.
  - date runs 01..month length and carries to month 01-12, which carries to year 00-99; year wraps 99 to 00.
  - weekday increments on date carry and wraps 6 to 0.
- Month length: 31 for months 01,03,05,07,08,10,12; 30 for 04,06,09,11. February is 29 if the year is a leap year, else 28.
- Leap year (year = 2000 + BCD): tens digit even with units in {0,4,8}, or tens digit odd with units in {2,6}.
- Out-of-range input: any field at or above its maximum counts as maximum when it carries. Examples: sec 0x60 carries to 00; date 0x32 in month 04 wraps to 01. A units digit above 9 is treated as 9.
- Simultaneous events:
  - Reload coinciding with a second tick: reload wins and the tick is dropped.
  - reset wins over everything.
- Reset mid-operation discards the running time; the first-load rule re-captures the HPS value on the first cycle after reset.
- valid stays 1 until reset. ce_10hz runs even while valid = 0.

Decomposition:
- Package rtc_pkg:
  - field offset constants SEC_LSB … WDAY_LSB and TOG_BIT
  - typedef rtc_time_t (packed struct matching the 65-bit layout)
  - functions bcd_inc_wrap(value, max, min) and days_in_month(month, year)
- Sub-module rtc_prescaler (CLK_HZ, TENTHS_PER_SEC): owns the prescaler, tenths, ce_10hz and the second tick; has a clear input driven by reload.
- Calendar registers and reload logic stay in the top.

Test Plan:
- Reset, then hps_rtc = {tog 1, wd 3, yr 24, mo 02, dt 28, 23:59:59} -> 1 cycle later rt_out matches with bit 64 = 1 and valid = 1; after 10 ce_10hz pulses rt_out = dt 29, 00:00:00, wd 4 (leap year).
- Same stimulus with yr 23 -> after 1 s rt_out = mo 03, dt 01, 00:00:00, wd 4.
- Load yr 99, mo 12, dt 31, 23:59:59, wd 6 -> after 1 s yr 00, mo 01, dt 01, 00:00:00, wd 0.
- With CLK_HZ = 100 in simulation -> ce_10hz high exactly 1 cycle in every 10; flip the hps_rtc toggle with the prescaler at 9 -> no pulse that cycle, next pulse 10 cycles after the reload.
- Load sec 0x60 -> after 1 s sec = 00, min +1.
- Assert reset for 1 cycle mid-count -> ce_10hz = 0 and valid = 0 in the reset cycle; the current hps_rtc is re-loaded 1 cycle after reset deasserts, with rt_out[64] toggled.
